// File: rtl/fib_pkg.sv
// Shared types and constants for the recursive Fibonacci sequencer.
package fib_pkg;

  localparam int unsigned N_W_DEF   = 5;
  localparam int unsigned RES_W_DEF = 16;
  localparam int unsigned DEPTH_DEF = 32;

  // Frame flag: which recursive call is still outstanding for the frame.
  localparam logic FLAG_FIRST  = 1'b0;
  localparam logic FLAG_SECOND = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    CALL,
    PUSH0_REQ,
    PUSH0_WAIT,
    RETURN,
    POP_REQ,
    POP_WAIT,
    DISPATCH,
    PUSH1_REQ,
    PUSH1_WAIT,
    DONE,
    ERROR
  } fibState_t;

  typedef enum logic [2:0] {
    P_IDLE,
    P_REQ,
    P_WAIT_LO,
    P_WAIT_HI,
    P_GAP
  } portState_t;

endpackage

// File: rtl/fib_recursion_sequencer_stack_req_port.sv
// REQ/WAIT/GAP handshake toward the frame stack controller.
module stack_req_port
  import fib_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic go_push,
  input  logic go_pop,
  input  logic readySig,
  output logic pushSig,
  output logic popSig,
  output logic op_done
);

  portState_t state, stateNext;
  logic readyPrev;
  logic pushNext, popNext, doneNext;

  // State and registered request/done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= P_IDLE;
      readyPrev <= 1'b0;
      pushSig   <= 1'b0;
      popSig    <= 1'b0;
      op_done   <= 1'b0;
    end else begin
      state     <= stateNext;
      readyPrev <= readySig;
      pushSig   <= pushNext;
      popSig    <= popNext;
      op_done   <= doneNext;
    end
  end

  // Issue only after two ready cycles, so the request never lands in a confirm cycle.
  always_comb begin
    stateNext = state;
    pushNext  = 1'b0;
    popNext   = 1'b0;
    doneNext  = 1'b0;
    case (state)
      P_IDLE: begin
        if ((go_push || go_pop) && readySig && readyPrev) begin
          stateNext = P_REQ;
          pushNext  = go_push;
          popNext   = !go_push;
        end
      end
      P_REQ:     stateNext = P_WAIT_LO;
      P_WAIT_LO: if (!readySig) stateNext = P_WAIT_HI;
      P_WAIT_HI: begin
        if (readySig) begin
          stateNext = P_GAP;
          doneNext  = 1'b1;
        end
      end
      P_GAP:     stateNext = P_IDLE;
      default:   stateNext = P_IDLE;
    endcase
  end

endmodule

// File: rtl/fib_recursion_sequencer.sv
// Recursive Fibonacci sequencer running its call frames on an external stack.
module fib_recursion_sequencer
  import fib_pkg::*;
#(
  parameter int unsigned N_W   = N_W_DEF,
  parameter int unsigned RES_W = RES_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_W-1:0]   n_in,
  input  logic             readySig,
  output logic             pushSig,
  output logic             popSig,
  output logic             push_flag,
  output logic [RES_W-1:0] push_ret,
  output logic [N_W-1:0]   push_n,
  input  logic             pop_flag,
  input  logic [RES_W-1:0] pop_ret,
  input  logic [N_W-1:0]   pop_n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [RES_W-1:0] result
);

  localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);

  fibState_t          state, stateNext;
  logic [N_W-1:0]     curN, curNNext;
  logic [RES_W-1:0]   ret, retNext;
  logic [DEPTH_W-1:0] depth, depthNext;
  logic               popFlagQ, popFlagNext;
  logic [RES_W-1:0]   popRetQ, popRetNext;
  logic [N_W-1:0]     popNQ, popNNext;
  logic               busyNext, doneNext, errNext;
  logic [RES_W-1:0]   resultNext;
  logic               pushFlagNext;
  logic [RES_W-1:0]   pushRetNext;
  logic [N_W-1:0]     pushNNext;
  logic               goPush, goPop, opDone;

  assign goPush = (state == PUSH0_REQ) || (state == PUSH1_REQ);
  assign goPop  = (state == POP_REQ);

  stack_req_port u_port (
    .clk      (clk),
    .rst_n    (rst_n),
    .go_push  (goPush),
    .go_pop   (goPop),
    .readySig (readySig),
    .pushSig  (pushSig),
    .popSig   (popSig),
    .op_done  (opDone)
  );

  // Recursion state, working registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      curN      <= '0;
      ret       <= '0;
      depth     <= '0;
      popFlagQ  <= 1'b0;
      popRetQ   <= '0;
      popNQ     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      result    <= '0;
      push_flag <= 1'b0;
      push_ret  <= '0;
      push_n    <= '0;
    end else begin
      state     <= stateNext;
      curN      <= curNNext;
      ret       <= retNext;
      depth     <= depthNext;
      popFlagQ  <= popFlagNext;
      popRetQ   <= popRetNext;
      popNQ     <= popNNext;
      busy      <= busyNext;
      done      <= doneNext;
      err       <= errNext;
      result    <= resultNext;
      push_flag <= pushFlagNext;
      push_ret  <= pushRetNext;
      push_n    <= pushNNext;
    end
  end

  // Call/return walk: first-call frames push {0,0,n}, second-call frames reuse the popped slot.
  always_comb begin
    stateNext    = state;
    curNNext     = curN;
    retNext      = ret;
    depthNext    = depth;
    popFlagNext  = popFlagQ;
    popRetNext   = popRetQ;
    popNNext     = popNQ;
    busyNext     = busy;
    doneNext     = done;
    errNext      = err;
    resultNext   = result;
    pushFlagNext = push_flag;
    pushRetNext  = push_ret;
    pushNNext    = push_n;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          curNNext  = n_in;
          depthNext = '0;
          doneNext  = 1'b0;
          errNext   = 1'b0;
          busyNext  = 1'b1;
          stateNext = CALL;
        end
      end
      CALL: begin
        if (curN < N_W'(2)) begin
          retNext   = RES_W'(curN);
          stateNext = RETURN;
        end else if (depth == DEPTH_W'(DEPTH)) begin
          errNext   = 1'b1;
          busyNext  = 1'b0;
          stateNext = ERROR;
        end else begin
          pushFlagNext = FLAG_FIRST;
          pushRetNext  = '0;
          pushNNext    = curN;
          stateNext    = PUSH0_REQ;
        end
      end
      PUSH0_REQ: if (pushSig) stateNext = PUSH0_WAIT;
      PUSH0_WAIT: begin
        if (opDone) begin
          depthNext = depth + DEPTH_W'(1);
          curNNext  = curN - N_W'(1);
          stateNext = CALL;
        end
      end
      RETURN: begin
        if (depth == '0) begin
          resultNext = ret;
          doneNext   = 1'b1;
          busyNext   = 1'b0;
          stateNext  = DONE;
        end else begin
          stateNext = POP_REQ;
        end
      end
      POP_REQ: if (popSig) stateNext = POP_WAIT;
      POP_WAIT: begin
        if (opDone) begin
          popFlagNext = pop_flag;
          popRetNext  = pop_ret;
          popNNext    = pop_n;
          depthNext   = depth - DEPTH_W'(1);
          stateNext   = DISPATCH;
        end
      end
      DISPATCH: begin
        if (popFlagQ == FLAG_FIRST) begin
          pushFlagNext = FLAG_SECOND;
          pushRetNext  = ret;
          pushNNext    = popNQ;
          stateNext    = PUSH1_REQ;
        end else begin
          retNext   = popRetQ + ret;
          stateNext = RETURN;
        end
      end
      PUSH1_REQ: if (pushSig) stateNext = PUSH1_WAIT;
      PUSH1_WAIT: begin
        if (opDone) begin
          depthNext = depth + DEPTH_W'(1);
          curNNext  = popNQ - N_W'(2);
          stateNext = CALL;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule
